// File: rtl/csr_pkg.sv
// Shared types and encodings for the CSR issue path: funct3 op codes,
// issue-unit FSM states and the latched request fields.
package csr_pkg;

  localparam logic [2:0] CSR_RW  = 3'b001;
  localparam logic [2:0] CSR_RS  = 3'b010;
  localparam logic [2:0] CSR_RC  = 3'b011;
  localparam logic [2:0] CSR_RWI = 3'b101;
  localparam logic [2:0] CSR_RSI = 3'b110;
  localparam logic [2:0] CSR_RCI = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_READ,
    ST_COMMIT,
    ST_REDIRECT
  } csr_issue_state_t;

  // Narrow request fields; the XLEN/CSR_AW-wide fields live in separately
  // sized registers so the module parameters stay overridable.
  typedef struct packed {
    logic [2:0] funct3;
    logic       is_mret;
    logic [4:0] rs1_idx;
    logic [4:0] rd;
  } csr_req_t;

endpackage

// File: rtl/csr_issue_unit_if.sv
// Execute-stage to CSR issue unit request channel (valid/ready handshake).
interface csr_issue_if #(
  parameter int XLEN   = 64,
  parameter int CSR_AW = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_funct3;
  logic              in_is_mret;
  logic [CSR_AW-1:0] in_csr_addr;
  logic [4:0]        in_rs1_idx;
  logic [XLEN-1:0]   in_rs1_val;
  logic [4:0]        in_rd;
  logic [XLEN-1:0]   in_pc;

  modport master (
    output in_valid, in_funct3, in_is_mret, in_csr_addr,
           in_rs1_idx, in_rs1_val, in_rd, in_pc,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_funct3, in_is_mret, in_csr_addr,
           in_rs1_idx, in_rs1_val, in_rd, in_pc,
    output in_ready
  );
endinterface

// File: rtl/csr_issue_unit_alu.sv
// New-value computation for Zicsr ops: RW/RS/RC in register and
// immediate (zimm) forms, plus write-enable and legality decode.
module csr_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [4:0]      rs1_idx,
  output logic [XLEN-1:0] new_val,
  output logic            write_en,
  output logic            legal
);

  logic [XLEN-1:0] operand;

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    operand  = funct3[2] ? XLEN'(rs1_idx) : rs1_val;
    new_val  = '0;
    write_en = 1'b0;
    legal    = 1'b1;
    case (funct3)
      CSR_RW, CSR_RWI: begin
        new_val  = operand;
        write_en = 1'b1;
      end
      CSR_RS, CSR_RSI: begin
        new_val  = old_val | operand;
        write_en = (rs1_idx != 5'd0);
      end
      CSR_RC, CSR_RCI: begin
        new_val  = old_val & ~operand;
        write_en = (rs1_idx != 5'd0);
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/csr_issue_unit.sv
// Serializing CSR/MRET issue unit: drain, read, one-cycle commit strobe,
// then redirect + flush of the front end.
module csr_issue_unit
  import csr_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              reset,
  csr_issue_if.slave        issue,
  input  logic              pipe_empty,
  output logic [CSR_AW-1:0] csr_read_addr,
  input  logic [XLEN-1:0]   csr_read_data,
  output logic              csr_write_valid,
  output logic [CSR_AW-1:0] csr_write_addr,
  output logic [XLEN-1:0]   csr_write_data,
  output logic              csr_is_mret,
  input  logic [XLEN-1:0]   csr_mepc,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              flush,
  output logic              illegal
);

  csr_issue_state_t  state_q, state_d;
  csr_req_t          req_q;
  logic [CSR_AW-1:0] addr_q;
  logic [XLEN-1:0]   rs1_val_q, pc_q, old_q;

  logic [XLEN-1:0]   alu_new;
  logic              alu_we, alu_legal;

  csr_alu #(.XLEN(XLEN)) u_alu (
    .funct3   (req_q.funct3),
    .old_val  (old_q),
    .rs1_val  (rs1_val_q),
    .rs1_idx  (req_q.rs1_idx),
    .new_val  (alu_new),
    .write_en (alu_we),
    .legal    (alu_legal)
  );

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values. The latched fields are cleared on reset too, so no
  // stale request data can reach the outputs after a mid-flight reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      addr_q    <= '0;
      rs1_val_q <= '0;
      pc_q      <= '0;
      old_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && issue.in_valid) begin
        req_q.funct3  <= issue.in_funct3;
        req_q.is_mret <= issue.in_is_mret;
        req_q.rs1_idx <= issue.in_rs1_idx;
        req_q.rd      <= issue.in_rd;
        addr_q        <= issue.in_csr_addr;
        rs1_val_q     <= issue.in_rs1_val;
        pc_q          <= issue.in_pc;
      end
      if (state_q == ST_READ) old_q <= csr_read_data;
    end
  end

  always_comb begin
    state_d         = state_q;
    issue.in_ready  = 1'b0;
    csr_read_addr   = addr_q;
    csr_write_valid = 1'b0;
    csr_write_addr  = '0;
    csr_write_data  = '0;
    csr_is_mret     = 1'b0;
    wb_valid        = 1'b0;
    wb_rd           = '0;
    wb_data         = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    flush           = 1'b0;
    illegal         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        issue.in_ready = 1'b1;
        csr_read_addr  = '0;
        if (issue.in_valid) state_d = ST_DRAIN;
      end
      ST_DRAIN:  if (pipe_empty) state_d = ST_READ;
      ST_READ:   state_d = ST_COMMIT;
      ST_COMMIT: begin
        state_d = ST_REDIRECT;
        // MRET takes priority over whatever funct3 was presented with it.
        if (req_q.is_mret) begin
          csr_is_mret = 1'b1;
        end else begin
          csr_write_valid = alu_we;
          csr_write_addr  = addr_q;
          csr_write_data  = alu_new;
          wb_valid        = alu_legal && (req_q.rd != 5'd0);
          wb_rd           = req_q.rd;
          wb_data         = old_q;
          illegal         = !alu_legal;
        end
      end
      ST_REDIRECT: begin
        state_d        = ST_IDLE;
        redirect_valid = 1'b1;
        flush          = 1'b1;
        redirect_pc    = req_q.is_mret ? csr_mepc : pc_q + XLEN'(4);
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_issue_unit.sv
// Self-checking bench for csr_issue_unit: directed scenarios plus random
// transactions against a per-instruction expectation model.
module tb_csr_issue_unit;

  localparam int XLEN   = 64;
  localparam int CSR_AW = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              pipe_empty;
  logic [CSR_AW-1:0] csr_read_addr;
  logic [XLEN-1:0]   csr_read_data;
  logic              csr_write_valid;
  logic [CSR_AW-1:0] csr_write_addr;
  logic [XLEN-1:0]   csr_write_data;
  logic              csr_is_mret;
  logic [XLEN-1:0]   csr_mepc;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              flush;
  logic              illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  csr_issue_if #(.XLEN(XLEN), .CSR_AW(CSR_AW)) issue ();

  csr_issue_unit #(.XLEN(XLEN), .CSR_AW(CSR_AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .issue           (issue),
    .pipe_empty      (pipe_empty),
    .csr_read_addr   (csr_read_addr),
    .csr_read_data   (csr_read_data),
    .csr_write_valid (csr_write_valid),
    .csr_write_addr  (csr_write_addr),
    .csr_write_data  (csr_write_data),
    .csr_is_mret     (csr_is_mret),
    .csr_mepc        (csr_mepc),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .flush           (flush),
    .illegal         (illegal)
  );

  typedef struct {
    logic            we;
    logic [XLEN-1:0] wdata;
    logic            wb;
    logic [XLEN-1:0] wbdata;
    logic            ill;
    logic            mret;
    logic [XLEN-1:0] rpc;
  } exp_t;

  // Architectural outcome of one CSR instruction, straight from the Zicsr rules.
  function automatic exp_t model(logic [2:0] f3, logic mret, logic [4:0] rs1_idx,
                                 logic [XLEN-1:0] rs1_val, logic [4:0] rd,
                                 logic [XLEN-1:0] pc, logic [XLEN-1:0] old,
                                 logic [XLEN-1:0] mepc);
    exp_t e;
    logic [XLEN-1:0] opnd;
    e = '{we: 0, wdata: 0, wb: 0, wbdata: 0, ill: 0, mret: 0, rpc: 0};
    if (mret) begin
      e.mret = 1;
      e.rpc  = mepc;
      return e;
    end
    e.rpc = pc + 64'd4;
    opnd  = (f3 >= 3'd5) ? {59'd0, rs1_idx} : rs1_val;
    if (f3 == 3'd1 || f3 == 3'd5) begin
      e.we = 1; e.wdata = opnd;
    end else if (f3 == 3'd2 || f3 == 3'd6) begin
      e.we = (rs1_idx != 0); e.wdata = old | opnd;
    end else if (f3 == 3'd3 || f3 == 3'd7) begin
      e.we = (rs1_idx != 0); e.wdata = old & ~opnd;
    end else begin
      e.ill = 1;
    end
    if (!e.ill) begin
      e.wb = (rd != 0); e.wbdata = old;
    end
    return e;
  endfunction

  function automatic logic [XLEN-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic scramble_inputs();
    issue.in_funct3   = 3'($urandom);
    issue.in_is_mret  = 1'($urandom);
    issue.in_csr_addr = 12'($urandom);
    issue.in_rs1_idx  = 5'($urandom);
    issue.in_rs1_val  = rnd64();
    issue.in_rd       = 5'($urandom);
    issue.in_pc       = rnd64();
  endtask

  // Offers one instruction in an IDLE cycle and checks every cycle up to and
  // including REDIRECT; drain = cycles pipe_empty stays low after accept.
  task automatic run_txn(input string name, input logic [2:0] f3, input logic mret,
                         input logic [11:0] addr, input logic [4:0] rs1_idx,
                         input logic [XLEN-1:0] rs1_val, input logic [4:0] rd,
                         input logic [XLEN-1:0] pc, input logic [XLEN-1:0] old,
                         input logic [XLEN-1:0] mepc, input int drain,
                         input logic valid_in_redirect);
    exp_t e;
    int   c;
    logic [5:0] got_s, exp_s;
    e = model(f3, mret, rs1_idx, rs1_val, rd, pc, old, mepc);
    c = 3 + drain;
    @(negedge clk);
    issue.in_valid = 1'b1;  issue.in_funct3 = f3;  issue.in_is_mret = mret;
    issue.in_csr_addr = addr;  issue.in_rs1_idx = rs1_idx;  issue.in_rs1_val = rs1_val;
    issue.in_rd = rd;  issue.in_pc = pc;
    pipe_empty = 1'($urandom);  csr_read_data = rnd64();  csr_mepc = rnd64();
    #1;
    n_tests++;
    if (issue.in_ready !== 1'b1 || csr_read_addr !== '0) begin
      n_fail++;
      $display("FAIL %s idle: in_ready=%b read_addr=%h, expected 1 and 0", name,
               issue.in_ready, csr_read_addr);
    end
    for (int k = 1; k <= c + 1; k++) begin
      @(negedge clk);
      scramble_inputs();
      issue.in_valid = (k == c + 1) ? valid_in_redirect : 1'($urandom);
      pipe_empty     = (k > drain);
      csr_read_data  = (k == c - 1) ? old : rnd64();
      csr_mepc       = (k == c + 1) ? mepc : rnd64();
      #1;
      got_s = {csr_write_valid, csr_is_mret, wb_valid, illegal, redirect_valid, flush};
      exp_s = {(k == c) && e.we, (k == c) && e.mret, (k == c) && e.wb, (k == c) && e.ill,
               k == c + 1, k == c + 1};
      n_tests++;
      if (got_s !== exp_s || issue.in_ready !== 1'b0 || csr_read_addr !== addr) begin
        n_fail++;
        $display("FAIL %s cycle %0d: strobes=%b ready=%b raddr=%h, expected %b 0 %h",
                 name, k, got_s, issue.in_ready, csr_read_addr, exp_s, addr);
      end
      if (k == c && e.we) begin
        n_tests++;
        if (csr_write_addr !== addr || csr_write_data !== e.wdata) begin
          n_fail++;
          $display("FAIL %s write: addr=%h data=%h, expected %h %h", name,
                   csr_write_addr, csr_write_data, addr, e.wdata);
        end
      end
      if (k == c && e.wb) begin
        n_tests++;
        if (wb_rd !== rd || wb_data !== e.wbdata) begin
          n_fail++;
          $display("FAIL %s wb: rd=%0d data=%h, expected %0d %h", name,
                   wb_rd, wb_data, rd, e.wbdata);
        end
      end
      if (k == c + 1) begin
        n_tests++;
        if (redirect_pc !== e.rpc) begin
          n_fail++;
          $display("FAIL %s redirect_pc: got %h, expected %h", name, redirect_pc, e.rpc);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    issue.in_valid = 1'b0;
    scramble_inputs();
    pipe_empty = 1'b0;  csr_read_data = rnd64();  csr_mepc = rnd64();
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (issue.in_ready !== 1'b1 ||
        {csr_write_valid, csr_is_mret, wb_valid, illegal, redirect_valid, flush} !== 6'b0 ||
        csr_read_addr !== '0 || csr_write_addr !== '0 || csr_write_data !== '0 ||
        wb_rd !== '0 || wb_data !== '0 || redirect_pc !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b strobes=%b raddr=%h wdata=%h wbdata=%h rpc=%h",
               issue.in_ready,
               {csr_write_valid, csr_is_mret, wb_valid, illegal, redirect_valid, flush},
               csr_read_addr, csr_write_data, wb_data, redirect_pc);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_txn("csrrw", 3'b001, 1'b0, 12'h340, 5'd7, 64'hABCD, 5'd5,
            64'h8000_0000, 64'h11, 64'h0, 0, 1'b0);
    run_txn("csrrs_x0", 3'b010, 1'b0, 12'h300, 5'd0, 64'hFFFF, 5'd0,
            64'h8000_0010, 64'h1888, 64'h0, 0, 1'b0);
    run_txn("csrrci", 3'b111, 1'b0, 12'h304, 5'd5, 64'hDEAD, 5'd3,
            64'h8000_0020, 64'hF, 64'h0, 0, 1'b0);
    run_txn("mret", 3'b000, 1'b1, 12'h000, 5'd0, 64'h0, 5'd0,
            64'h8000_0030, 64'h0, 64'h8000_0100, 0, 1'b0);
  endtask

  task automatic test_drain();
    run_txn("drain6", 3'b101, 1'b0, 12'h340, 5'd21, 64'h0, 5'd9,
            64'h8000_0040, 64'h1234_5678, 64'h0, 6, 1'b0);
  endtask

  task automatic test_illegal();
    run_txn("illegal100", 3'b100, 1'b0, 12'h305, 5'd3, 64'h55, 5'd4,
            64'h8000_0050, 64'h77, 64'h0, 0, 1'b0);
    run_txn("illegal000", 3'b000, 1'b0, 12'h305, 5'd3, 64'h55, 5'd4,
            64'hFFFF_FFFF_FFFF_FFFC, 64'h77, 64'h0, 1, 1'b0);
    run_txn("mret_wins", 3'b001, 1'b1, 12'h340, 5'd1, 64'h99, 5'd6,
            64'h8000_0060, 64'h5, 64'h8000_0200, 0, 1'b0);
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    issue.in_valid = 1'b1;  issue.in_funct3 = 3'b001;  issue.in_is_mret = 1'b0;
    issue.in_csr_addr = 12'h340;  issue.in_rs1_idx = 5'd2;  issue.in_rs1_val = 64'h42;
    issue.in_rd = 5'd8;  issue.in_pc = 64'h8000_0070;  pipe_empty = 1'b1;
    @(negedge clk);
    issue.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_tests++;
      if (issue.in_ready !== 1'b1 ||
          {csr_write_valid, csr_is_mret, wb_valid, illegal, redirect_valid, flush} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_midflight cycle %0d: ready=%b strobes=%b, expected 1 000000", k,
                 issue.in_ready,
                 {csr_write_valid, csr_is_mret, wb_valid, illegal, redirect_valid, flush});
      end
    end
  endtask

  task automatic test_redirect_ignore();
    run_txn("valid_in_redirect", 3'b110, 1'b0, 12'h344, 5'd4, 64'h0, 5'd10,
            64'h8000_0080, 64'h3, 64'h0, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      issue.in_valid = 1'b0;
      #1;
      n_tests++;
      if (issue.in_ready !== 1'b1 || csr_read_addr !== '0 ||
          {csr_write_valid, csr_is_mret, wb_valid, illegal, redirect_valid, flush} !== 6'b0) begin
        n_fail++;
        $display("FAIL redirect_ignore idle %0d: ready=%b raddr=%h, expected 1 0", k,
                 issue.in_ready, csr_read_addr);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3;
    logic [4:0]  idx;
    for (int i = 0; i < 40; i++) begin
      f3  = 3'($urandom);
      idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      run_txn($sformatf("random%0d", i), f3, ($urandom_range(0, 7) == 0),
              12'($urandom), idx, rnd64(), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
              rnd64(), rnd64(), rnd64(), $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_drain();
    test_illegal();
    test_reset_midflight();
    test_redirect_ignore();
    test_back_to_back();
    @(negedge clk);
    issue.in_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_issue_unit.md
Name: csr_issue_unit

Overview:
- Pipeline-side initiator for the machine-mode CSR register file.
- Accepts one CSR instruction (CSRRW/S/C, CSRRWI/SI/CI) or MRET from the execute stage and serializes it:
  - waits for older instructions to drain;
  - reads the CSR and computes the new value;
  - drives the one-cycle write or MRET strobe into the CSR file;
  - writes the old value back to rd;
  - redirects and flushes the front end.
- Sits between execute and the CSR file, in place of a direct W-stage connection.

Parameters:
- XLEN, 64, data width of CSR and GPR values.
- CSR_AW, 12, CSR address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  CSR/MRET instruction offered.
- in_ready  out  1  unit idle and able to accept.
- in_funct3  in  3  CSR op encoding: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- in_is_mret  in  1  instruction is MRET; in_funct3 is ignored.
- in_csr_addr  in  12  target CSR.
- in_rs1_idx  in  5  rs1 index; for the immediate forms this field is the zimm.
- in_rs1_val  in  XLEN  rs1 operand value.
- in_rd  in  5  destination register.
- in_pc  in  XLEN  instruction PC.
- pipe_empty  in  1  all older instructions have retired.
- csr_read_addr  out  12  CSR file read address.
- csr_read_data  in  XLEN  CSR file combinational read data.
- csr_write_valid  out  1  CSR write strobe.
- csr_write_addr  out  12  CSR write address.
- csr_write_data  out  XLEN  CSR write data.
- csr_is_mret  out  1  MRET strobe to the CSR file.
- csr_mepc  in  XLEN  current mepc from the CSR file.
- wb_valid  out  1  GPR writeback strobe.
- wb_rd  out  5  writeback register.
- wb_data  out  XLEN  writeback data (old CSR value).
- redirect_valid  out  1  front-end redirect.
- redirect_pc  out  XLEN  redirect target.
- flush  out  1  squash younger instructions.
- illegal  out  1  pulse: reserved funct3 (000 or 100) was accepted.

Behaviour:
- Reset: state IDLE; all latched fields cleared.
  - All strobes are 0: csr_write_valid, csr_is_mret, wb_valid, redirect_valid, flush, illegal.
  - All data outputs are 0.
  - in_ready = 1.
- FSM states: IDLE, DRAIN, READ, COMMIT, REDIRECT.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch all in_* fields and go to DRAIN.
- DRAIN:
  - in_ready = 0.
  - Stay while pipe_empty = 0; go to READ when pipe_empty = 1.
  - Always at least one cycle in DRAIN.
- READ:
  - Capture old = csr_read_data into a register; go to COMMIT.
  - For MRET, no capture is needed; still one cycle in READ.
- COMMIT (exactly one cycle):
  - New-value arithmetic: op = rs1_val for register forms, or zimm zero-extended to XLEN for immediate forms.
    - RW: new = op.
    - RS: new = old | op.
    - RC: new = old & ~op.
  - Write enable:
    - RW/RWI: always.
    - RS/RC/RSI/RCI: only when rs1_idx/zimm != 0.
    - Reserved funct3: never.
  - csr_write_valid = write enable; csr_write_addr = latched address; csr_write_data = new.
  - wb_valid = 1 iff the op is legal, not MRET, and rd != 0; wb_data = old.
  - MRET: csr_is_mret = 1, csr_write_valid = 0, wb_valid = 0.
  - Reserved funct3: illegal = 1; no write, no wb.
  - Go to REDIRECT.
- REDIRECT (exactly one cycle):
  - redirect_valid = 1, flush = 1.
  - redirect_pc = csr_mepc for MRET, else latched pc + 4 (mod 2^XLEN).
  - Go to IDLE.
- Latency: with pipe_empty already high at accept, the write strobe occurs 3 cycles after accept and the redirect 4 cycles after.
- Throughput: one instruction per 5 cycles minimum.
- csr_read_addr is driven from the latched address in all states other than IDLE; it is 0 in IDLE.
- in_valid and in_is_mret are never both asserted with a legal funct3 by upstream. If they are, MRET wins.
- Reset in any state returns to IDLE the next cycle with no strobe issued. An in-flight instruction is dropped.
- in_valid is ignored whenever in_ready = 0; inputs are not re-sampled after the accept cycle.
- All strobes are single-cycle pulses and are never asserted simultaneously across COMMIT/REDIRECT.

Decomposition:
- Add to csr_pkg:
  - funct3 constants: CSR_RW, CSR_RS, CSR_RC, CSR_RWI, CSR_RSI, CSR_RCI;
  - the csr_issue_state_t enum;
  - a latched-request struct.
- Sub-module csr_alu (combinational): funct3, old, rs1_val, rs1_idx → new, write_en, legal.

Test Plan:
- CSRRW x5, mscratch (csr_read_data = 0x11), rs1_val = 0xABCD, pipe_empty = 1, pc = 0x8000_0000:
  - csr_write_valid with data 0xABCD at accept+3;
  - wb rd = 5, data 0x11;
  - redirect_pc = 0x8000_0004 at accept+4.
- CSRRS x0, mstatus, rs1_idx = 0:
  - no csr_write_valid, no wb_valid;
  - redirect + flush still pulse.
- CSRRCI x3, mie, zimm = 0x5, old = 0xF:
  - write data 0xA;
  - wb_data 0xF.
- MRET with csr_mepc = 0x8000_0100:
  - csr_is_mret pulse, no write, no wb;
  - redirect_pc = 0x8000_0100.
- pipe_empty held low 6 cycles after accept:
  - unit stays in DRAIN, in_ready = 0, no strobes;
  - write occurs 2 cycles after pipe_empty rises.
- Reset asserted in COMMIT-1 (READ), and a second in_valid arrives during REDIRECT:
  - after reset, no write or redirect pulses appear and in_ready = 1;
  - the in_valid during REDIRECT is ignored;
  - funct3 = 100 → illegal pulse, no write, redirect to pc + 4.
